// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-addressed load/store unit in front of a word-only memory (optional range check: LSU_RANGE_CHECK_EN)
module lsu_mem_ctrl #(
  parameter int DEPTH = 101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_ad_o,
  output logic [31:0] mem_wr_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rd_i
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4, SW = 3'd5, SB = 3'd6, SH = 3'd7;
`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d, ad_q, ad_d, wr_q, wr_d;
  logic        err_q, err_d, rsp_valid_q, we_q, re_q;
  logic [31:0] idx, ld_v, st_v;
  logic        mis, oor, acc_err;
  logic [4:0]  sh_b, sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // Accept-time checks plus load extraction and store merge on the word just read
  always_comb begin
    idx = {2'b00, req_addr_i[31:2]};
    mis = (req_op_i == LW || req_op_i == SW) ? |req_addr_i[1:0] :
          (req_op_i == LH || req_op_i == LHU || req_op_i == SH) ? req_addr_i[0] : 1'b0;
    oor = RANGE_CHK && (idx >= 32'(DEPTH));
    acc_err = mis || oor;
    sh_b = {lane_q, 3'b000};
    sh_h = {lane_q[1], 4'b0000};
    byte_v = 8'(mem_rd_i >> sh_b);
    half_v = lane_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    ld_v = op_q == LB  ? {{24{byte_v[7]}}, byte_v} :
           op_q == LBU ? {24'b0, byte_v} :
           op_q == LH  ? {{16{half_v[15]}}, half_v} :
           op_q == LHU ? {16'b0, half_v} : mem_rd_i;
    st_v = op_q == SB ? (mem_rd_i & ~(32'hFF << sh_b)) | ({24'b0, wdata_q[7:0]} << sh_b) :
                        (mem_rd_i & ~(32'hFFFF << sh_h)) | ({16'b0, wdata_q} << sh_h);
  end
  // Next-state and next values of the registered memory/response outputs
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    lane_d = lane_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    ad_d = ad_q;
    wr_d = wr_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        op_d = req_op_i;
        lane_d = req_addr_i[1:0];
        wdata_d = req_wdata_i[15:0];
        rdata_d = '0;
        err_d = acc_err;
        state_d = acc_err ? RESP : req_op_i == SW ? WRITE : READ;
        ad_d = acc_err ? ad_q : idx;
        wr_d = (!acc_err && req_op_i == SW) ? req_wdata_i : wr_q;
      end
      READ: begin
        state_d = op_q >= SW ? WRITE : RESP;
        rdata_d = op_q >= SW ? '0 : ld_v;
        wr_d = op_q >= SW ? st_v : wr_q;
      end
      WRITE: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // State and all memory-facing strobes are flops so the memory never sees glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= LW;
      lane_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      ad_q <= '0;
      wr_q <= '0;
      rsp_valid_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      lane_q <= lane_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      ad_q <= ad_d;
      wr_q <= wr_d;
      rsp_valid_q <= state_d == RESP;
      we_q <= state_d == WRITE;
      re_q <= state_d == READ;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o = err_q;
  assign mem_ad_o = ad_q;
  assign mem_wr_o = wr_q;
  assign mem_we_o = we_q;
  assign mem_re_o = re_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of lsu_mem_ctrl against a small behavioural word memory
module tb_lsu_mem_ctrl;
  localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4, SW = 3'd5, SB = 3'd6, SH = 3'd7;
  logic        clk, rst, req_valid, req_ready, rsp_valid, rsp_err, mem_we, mem_re;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_ad, mem_wr, mem_rd;
  logic [31:0] mem [0:127];
  logic        pre_we;
  logic [6:0]  pre_a;
  logic [31:0] pre_d;
  int total = 0;
  int bad = 0;

  lsu_mem_ctrl #(.DEPTH(101)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_ad_o(mem_ad), .mem_wr_o(mem_wr), .mem_we_o(mem_we), .mem_re_o(mem_re),
    .mem_rd_i(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && mem_ad < 32'd128) mem[mem_ad[6:0]] <= mem_wr;
    else if (pre_we) mem[pre_a] <= pre_d;
  end
  assign mem_rd = (mem_ad < 32'd128) ? mem[mem_ad[6:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [31:0] d);
    pre_a = a;
    pre_d = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp);
    go(op, addr, 32'h0);
    chk({tag, "_re"}, {31'b0, mem_re}, 32'd1);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_err"}, {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
  endtask

  task automatic err_chk(input string tag, input logic [2:0] op, input logic [31:0] addr);
    go(op, addr, 32'h1234_5678);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_err"}, {31'b0, rsp_err}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_strobes"}, {30'b0, mem_re, mem_we}, 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, {30'b0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = LW;
    req_addr = '0;
    req_wdata = '0;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_flags", {28'b0, rsp_valid, rsp_err, mem_we, mem_re}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ad", mem_ad, 32'd0);
    chk("rst_wr", mem_wr, 32'd0);
    poke(7'd1, 32'h80FF_1234);
    poke(7'd2, 32'd9);
    poke(7'd101, 32'h0000_0055);
    go(LW, 32'h8, 32'h0);
    chk("lw_re", {30'b0, mem_re, mem_we}, 32'd2);
    chk("lw_ad", mem_ad, 32'd2);
    chk("lw_busy", {30'b0, req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lw_valid", {31'b0, rsp_valid}, 32'd1);
    chk("lw_rdata", rsp_rdata, 32'd9);
    chk("lw_err", {31'b0, rsp_err}, 32'd0);
    chk("lw_strobes", {30'b0, mem_re, mem_we}, 32'd0);
    @(negedge clk);
    chk("lw_done", {30'b0, req_ready, rsp_valid}, 32'd2);
    load_chk("lb", LB, 32'h7, 32'hFFFF_FF80);
    load_chk("lbu", LBU, 32'h7, 32'h0000_0080);
    load_chk("lh", LH, 32'h6, 32'hFFFF_80FF);
    load_chk("lhu0", LHU, 32'h4, 32'h0000_1234);
    poke(7'd1, 32'h1122_3344);
    go(SB, 32'h5, 32'h0000_00AB);
    chk("sb_read", {30'b0, mem_re, mem_we}, 32'd2);
    @(negedge clk);
    chk("sb_write", {30'b0, mem_re, mem_we}, 32'd1);
    chk("sb_wr", mem_wr, 32'h1122_AB44);
    chk("sb_ad", mem_ad, 32'd1);
    chk("sb_early", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("sb_valid", {31'b0, rsp_valid}, 32'd1);
    chk("sb_err_rdata", {rsp_rdata[30:0], rsp_err}, 32'd0);
    @(negedge clk);
    load_chk("sb_lw", LW, 32'h4, 32'h1122_AB44);
    err_chk("lw_mis", LW, 32'h6);
    err_chk("sh_mis", SH, 32'h5);
    err_chk("sw_mis", SW, 32'h2);
    go(SH, 32'hA, 32'h1357_BEEF);
    @(negedge clk);
    chk("sh_wr", mem_wr, 32'hBEEF_0009);
    chk("sh_we", {30'b0, mem_re, mem_we}, 32'd1);
    @(negedge clk);
    chk("sh_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk);
    load_chk("sh_lhu", LHU, 32'hA, 32'h0000_BEEF);
    load_chk("sh_lh", LH, 32'hA, 32'hFFFF_BEEF);
    load_chk("sh_lw", LW, 32'h8, 32'hBEEF_0009);
`ifdef LSU_RANGE_CHECK_EN
    err_chk("oor", LW, 32'd404);
`else
    go(LW, 32'd404, 32'h0);
    chk("oor_ad", mem_ad, 32'd101);
    chk("oor_re", {31'b0, mem_re}, 32'd1);
    @(negedge clk);
    chk("oor_valid", {30'b0, rsp_valid, rsp_err}, 32'd2);
    chk("oor_rdata", rsp_rdata, 32'h0000_0055);
    @(negedge clk);
`endif
    go(SW, 32'hC, 32'hDEAD_BEEF);
    chk("sw_we", {30'b0, mem_re, mem_we}, 32'd1);
    chk("sw_wr", mem_wr, 32'hDEAD_BEEF);
    chk("sw_ad", mem_ad, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_flags", {29'b0, rsp_valid, mem_we, mem_re}, 32'd0);
    chk("mid_rst_mem", mem[3], 32'hDEAD_BEEF);
    @(negedge clk);
    chk("mid_rst_novalid", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b1;
    req_op = LW;
    req_addr = 32'h8;
    req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    chk("rst_prio_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_prio_re", {30'b0, mem_re, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rst_prio_idle", {29'b0, req_ready, mem_re, rsp_valid}, 32'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the EX/MEM pipeline boundary and the word-addressed data memory `Mem`. It accepts one byte-addressed load or store per handshake and converts the byte address to a word index. It performs read-modify-write for sub-word stores, since `Mem` only writes full words, and sign- or zero-extends sub-word loads. It drives `Mem`'s `ad`, `wr`, `memtowrite` and `memtoread` from registers only, so the level-sensitive memory never sees glitches.

## Interface
- `DEPTH`, 101: number of 32-bit words in the attached memory.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept; equals (state == IDLE).
- `req_op`  in  3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data; sub-word stores use the low bits.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  32: load result; 0 for stores and errors.
- `rsp_err`  out  1: misaligned or out-of-range request; qualified by `rsp_valid`.
- `mem_ad`  out  32: word index, equal to `req_addr >> 2`; connects to `Mem.ad`.
- `mem_wr`  out  32: write word; connects to `Mem.wr`.
- `mem_we`  out  1: connects to `Mem.memtowrite`.
- `mem_re`  out  1: connects to `Mem.memtoread`.
- `mem_rd`  in  32: connects to `Mem.read`.

## Operation
- **States:** IDLE, READ, WRITE, RESP. The request (op, addr, wdata) is latched on the accept edge, when `req_valid` and `req_ready` are both high.
- **Error checks at accept:**
  - Misaligned: LW/SW with addr[1:0] ≠ 0, or LH/LHU/SH with addr[0] ≠ 0.
  - Out of range: see Configuration.
  - Any error goes IDLE → RESP with `rsp_err`=1. No memory access is made.
- **Transitions from IDLE:**
  - Loads, SB, SH: IDLE → READ.
  - SW: IDLE → WRITE.
- **READ:** `mem_re`=1, `mem_ad`=index. `mem_rd` is captured at the end of the cycle.
  - Loads go READ → RESP with the extracted value.
  - SB/SH go READ → WRITE with the merged word.
- **WRITE:** `mem_we`=1 with `mem_ad` and `mem_wr` stable for the whole cycle, then WRITE → RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then RESP → IDLE.
- **Byte order:** little-endian. Byte lane = addr[1:0], with lane 0 = bits 7:0. Halfword lane = addr[1], with lane 0 = bits 15:0.
- **Load extension:** LB/LH sign-extend; LBU/LHU zero-extend.
- **Store merge:** SB replaces only the addressed byte; SH replaces only the addressed halfword; all other bits keep the value read.
- `mem_we` and `mem_re` are never high together, and both are 0 outside READ and WRITE.
- **Back-to-back requests:** a new request is accepted only in IDLE, so RESP→IDLE costs one cycle. `req_valid` held during non-IDLE states is ignored.

## Timing
- **Latency from accept edge to the `rsp_valid` cycle:**
  - Error: 1 cycle.
  - LW/LB/LBU/LH/LHU/SW: 2 cycles.
  - SB/SH: 3 cycles.
- `mem_*` outputs are flop outputs that change only on `clk` edges. `mem_ad` and `mem_wr` hold their last values when idle.
- **Reset values:**
  - State = IDLE, so `req_ready`=1.
  - `rsp_valid`, `rsp_err`, `mem_we`, `mem_re` = 0.
  - `rsp_rdata`, `mem_ad`, `mem_wr` = 0.
- **Reset mid-operation:** the state returns to IDLE at the reset edge and no `rsp_valid` is issued. `mem_we`/`mem_re` drop at that edge. A write already presented during a completed WRITE cycle has taken effect; a partially completed RMW (READ done, WRITE not yet entered) leaves memory unchanged.
- **Reset has priority:** `rst` and `req_valid` high in the same cycle means no request is accepted.

## Configuration
- `LSU_RANGE_CHECK_EN` defined: a word index ≥ `DEPTH` sets `rsp_err`=1 with no memory access, 1-cycle latency.
- `LSU_RANGE_CHECK_EN` undefined: no range check. The index is driven onto `mem_ad` unchanged and the access proceeds normally. The alignment check is always present.

## Test plan
- LW addr 0x8, memory word 2 = 9 → READ cycle with `mem_re`=1, `mem_ad`=2; `rsp_valid` 2 cycles after accept with `rsp_rdata`=9, `rsp_err`=0.
- Word 1 = 0x80FF1234: LB addr 0x7 → `rsp_rdata`=0xFFFFFF80; LBU addr 0x7 → 0x00000080; LH addr 0x6 → 0xFFFF80FF.
- SB wdata 0x000000AB to addr 0x5, word 1 = 0x11223344 → READ, then WRITE with `mem_wr`=0x1122AB44, `mem_ad`=1; `rsp_valid` 3 cycles after accept; a subsequent LW 0x4 returns 0x1122AB44.
- LW addr 0x6 → `rsp_err`=1, `rsp_valid` 1 cycle after accept, `mem_re` and `mem_we` both 0 throughout.
- LW addr 404 (index 101): with `LSU_RANGE_CHECK_EN` → `rsp_err`=1 and no access; without it → READ with `mem_ad`=101.
- SW 0xDEADBEEF to addr 0xC with `rst` asserted in the WRITE cycle → next cycle state is IDLE, `req_ready`=1, `mem_we`=0, no `rsp_valid`.
